// File: rtl/prod_div_pkg.sv
// prod_div_pkg: shared sequencer state encodings and default widths for the product divider.
`ifndef PROD_DIV_DEFS
`define PROD_DIV_DEFS
`define PD_ST_IDLE 2'd0
`define PD_ST_PREP 2'd1
`define PD_ST_DIV  2'd2
`define PD_ST_FIX  2'd3
`define PD_WN      32
`define PD_WD      16
`endif

package prod_div_pkg;
  localparam int WN_DEF = `PD_WN;
  localparam int WD_DEF = `PD_WD;
  typedef enum logic [1:0] {
    IDLE = `PD_ST_IDLE,
    PREP = `PD_ST_PREP,
    DIV  = `PD_ST_DIV,
    FIX  = `PD_ST_FIX
  } state_t;
endpackage

// File: rtl/prod_div_div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(
  parameter int WD = 16
) (
  input  logic [WD:0] rem_i,
  input  logic        bit_i,
  input  logic [WD:0] dvs_i,
  output logic [WD:0] rem_o,
  output logic        q_o
);
  logic [WD+1:0] sh;
  logic [WD:0]   diff;
  always_comb begin
    sh    = {rem_i, bit_i};
    q_o   = sh >= {1'b0, dvs_i};
    diff  = sh[WD:0] - dvs_i;
    rem_o = q_o ? diff : sh[WD:0];
  end
endmodule

// File: rtl/prod_div.sv
// prod_div: sequential signed restoring divider of the (x+y)(x-y) product by a 16-bit divisor.
module prod_div
  import prod_div_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);
  localparam int CW = $clog2(WN + 1);
  state_t        state_q, state_d;
  logic [WN-1:0] a_q, a_d;
  logic [WD-1:0] b_q, b_d;
  logic [WN-1:0] dvd_q, dvd_d;
  logic [WD:0]   dvs_q, dvs_d;
  logic [WD:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WN-1:0] quotient_q, quotient_d;
  logic [WD-1:0] remainder_q, remainder_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  logic [WN-1:0] a_mag;
  logic [WD:0]   b_x, b_mag;
  logic [WD:0]   step_rem;
  logic          step_q;
  logic          neg_q;
  logic          ovf_case;
  div_step #(.WD(WD)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WN-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );
  // magnitudes are unsigned, so the most negative operands map cleanly onto their MSB
  always_comb begin
    a_mag    = a_q[WN-1] ? -a_q : a_q;
    b_x      = {b_q[WD-1], b_q};
    b_mag    = b_x[WD] ? -b_x : b_x;
    neg_q    = a_q[WN-1] ^ b_q[WD-1];
    ovf_case = (a_q == {1'b1, {(WN-1){1'b0}}}) && (b_q == '1);
  end
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_q == '0) begin
          quotient_d  = '1;
          remainder_d = '0;
          dz_d        = 1'b1;
          ovf_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = CW'(WN);
          state_d = DIV;
        end
      end
      DIV: begin
        dvd_d   = {dvd_q[WN-2:0], step_q};
        rem_d   = step_rem;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIX : DIV;
      end
      FIX: begin
        // the partial remainder stays below |divisor| <= 2^15, so its low WD bits are exact
        quotient_d  = neg_q ? -dvd_q : dvd_q;
        remainder_d = a_q[WN-1] ? -rem_q[WD-1:0] : rem_q[WD-1:0];
        done_d      = 1'b1;
        dz_d        = 1'b0;
        ovf_d       = ovf_case;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;
endmodule
